// File: rtl/ntt_pkg.sv
// Shared constants and FSM state type for the NTT coefficient loader and its
// Barrett reduction stage.
package ntt_pkg;

  localparam int N             = 256;
  localparam int LOGN          = 8;
  localparam int DW            = 16;
  localparam int Q             = 3329;
  localparam int BARRETT_V     = 20159;
  localparam int BARRETT_SHIFT = 26;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_WAIT_HI,
    ST_WAIT_LO
  } ntt_ld_state_t;

endpackage

// File: rtl/coeff_barrett_reduce.sv
// One registered Barrett stage: reduces an unsigned DATA_W-bit word modulo MOD.
// Output data is forced to zero on cycles without a valid beat.
module coeff_barrett_reduce
  import ntt_pkg::*;
#(
  parameter int DATA_W = DW,
  parameter int MOD    = Q,
  parameter int MULT   = BARRETT_V,
  parameter int SHIFT  = BARRETT_SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  localparam int PW = DATA_W + $clog2(MULT) + 1;

  logic [PW-1:0]     prod;
  logic [PW-1:0]     quot;
  logic [DATA_W:0]   tq;
  logic [DATA_W:0]   r;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // The remainder fits in DATA_W+1 bits, so truncating t*MOD is safe.
  always_comb begin
    prod = PW'(in_data) * PW'(MULT);
    quot = prod >> SHIFT;
    tq   = (DATA_W+1)'(quot * PW'(MOD));
    r    = {1'b0, in_data} - tq;
    if (r >= (DATA_W+1)'(MOD)) begin
      r = r - (DATA_W+1)'(MOD);
    end
    valid_d = in_valid;
    data_d  = in_valid ? r[DATA_W-1:0] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/ntt_coeff_loader.sv
// Streams a coefficient frame into the NTT BRAM, then kicks and tracks the transform.
// Define NTT_LOADER_BITREV_EN to write coefficients at bit-reversed addresses.
module ntt_coeff_loader #(
  parameter int N  = ntt_pkg::N,
  parameter int DW = ntt_pkg::DW,
  parameter int Q  = ntt_pkg::Q,
  parameter int AW = ntt_pkg::LOGN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic          in_mode,
  output logic          bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_din,
  output logic          ntt_start,
  output logic          ntt_mode,
  input  logic          ntt_done,
  output logic          busy,
  output logic          frame_done,
  output logic          err_len
);

  import ntt_pkg::ntt_ld_state_t, ntt_pkg::ST_IDLE, ntt_pkg::ST_LOAD, ntt_pkg::ST_KICK,
         ntt_pkg::ST_WAIT_HI, ntt_pkg::ST_WAIT_LO;

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  ntt_ld_state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] idx_map;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    kick_q, kick_d;
  logic          mode_q, mode_d;
  logic          err_q, err_d;
  logic          in_ready_q, in_ready_d;
  logic          frame_done_q, frame_done_d;
  logic          accept;

  assign accept = in_valid & in_ready_q;

`ifdef NTT_LOADER_BITREV_EN
  for (genvar gi = 0; gi < AW; gi++) begin : g_bitrev
    assign idx_map[gi] = idx_q[AW-1-gi];
  end
`else
  assign idx_map = idx_q;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    kick_d       = kick_q;
    mode_d       = mode_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    addr_d       = accept ? idx_map : '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mode_d = in_mode;
          err_d  = 1'b0;
          if (in_last) begin
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (in_last) begin
              kick_d  = '0;
              state_d = ST_KICK;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (in_last) begin
            err_d   = 1'b1;
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      // Count 0 lets the last write retire; counts 1 and 2 drive the start pulse.
      ST_KICK: begin
        kick_d = kick_q + 1'b1;
        if (kick_q == 2'd2) begin
          kick_d  = '0;
          state_d = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (ntt_done) state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!ntt_done) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      addr_q       <= '0;
      kick_q       <= '0;
      mode_q       <= 1'b0;
      err_q        <= 1'b0;
      in_ready_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      kick_q       <= kick_d;
      mode_q       <= mode_d;
      err_q        <= err_d;
      in_ready_q   <= in_ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  coeff_barrett_reduce #(
    .DATA_W (DW),
    .MOD    (Q)
  ) u_reduce (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_data   (in_data),
    .out_valid (bram_we),
    .out_data  (bram_din)
  );

  assign in_ready   = in_ready_q;
  assign bram_addr  = addr_q;
  assign ntt_start  = (state_q == ST_KICK) && (kick_q != 2'd0);
  assign ntt_mode   = mode_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign err_len    = err_q;

endmodule

// File: tb/tb_ntt_coeff_loader.sv
// Randomized bench for ntt_coeff_loader against a frame-level reference model
// (expected writes = index order and x mod Q) plus a behavioural wrapper.
module tb_ntt_coeff_loader;

  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_mode = 1'b0;
  logic        ntt_done = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, bram_we, ntt_start, ntt_mode, busy, frame_done, err_len;
  logic [7:0]  bram_addr;
  logic [15:0] bram_din;

  ntt_coeff_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_mode    (in_mode),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .ntt_start  (ntt_start),
    .ntt_mode   (ntt_mode),
    .ntt_done   (ntt_done),
    .busy       (busy),
    .frame_done (frame_done),
    .err_len    (err_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] got_q[$];
  logic [23:0] exp_q[$];
  logic [15:0] corners [4] = '{16'd3328, 16'd3329, 16'd6658, 16'd65535};

  int   last_we_cyc = 0, start_rise_cyc = 0, start_run = 0, start_cnt = 0;
  int   fd_cnt = 0, fd_cyc = 0;
  logic fd_ready = 1'b0, mode_at_start = 1'b0, prev_start = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_addr(input int i);
    logic [7:0] a, r;
    a = 8'(i);
    r = a;
`ifdef NTT_LOADER_BITREV_EN
    for (int b = 0; b < 8; b++) r[b] = a[7-b];
`endif
    return r;
  endfunction

  // Observes the DUT mid-cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (bram_we) begin
      got_q.push_back({bram_addr, bram_din});
      last_we_cyc = cyc;
    end
    if (ntt_start) begin
      if (!prev_start) begin
        start_rise_cyc = cyc;
        start_cnt++;
        start_run = 0;
        mode_at_start = ntt_mode;
      end
      start_run++;
    end
    prev_start = ntt_start;
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
      fd_ready = in_ready;
    end
  end

  task automatic send_beat(input logic [15:0] d, input logic last, input logic m, input int gap);
    logic acc;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_mode  = m;
    acc = 1'b0;
    for (int w = 0; w < 50 && !acc; w++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit with_last, input logic m, input int kind, input bit gaps);
    logic [15:0] d;
    start_cnt = 0;
    fd_cnt = 0;
    for (int i = 0; i < len; i++) begin
      if (kind == 0) d = 16'(i);
      else if (i < 4) d = corners[i];
      else d = 16'($urandom_range(0, 65535));
      exp_q.push_back({exp_addr(i), 16'(d % Q)});
      send_beat(d, with_last && (i == len - 1), m, gaps ? int'($urandom_range(0, 2)) : 0);
      if (i == 0 && len > 1) check("err_clr_first", err_len, 0);
    end
  endtask

  task automatic compare_writes(input string tag);
    repeat (2) begin @(posedge clk); #1; end
    check({tag, "_wr_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_wr_addr"}, got_q[i][23:16], exp_q[i][23:16]);
      check({tag, "_wr_data"}, got_q[i][15:0], exp_q[i][15:0]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Behavioural wrapper: waits for start, answers with a 3-cycle done after a delay.
  task automatic run_transform(input logic m, input int delay, input bit spurious);
    bit seen, ready_hi;
    int fall_cyc;
    seen = 0;
    for (int w = 0; w < 10 && !seen; w++) begin
      if (ntt_start) seen = 1;
      else begin @(posedge clk); #1; end
    end
    if (!seen) begin
      check("start_timeout", 0, 1);
      return;
    end
    if (spurious) begin
      ntt_done = 1'b1;
      @(posedge clk); #1;
      ntt_done = 1'b0;
    end
    ready_hi = 0;
    repeat (delay) begin
      @(posedge clk); #1;
      if (in_ready || !busy) ready_hi = 1;
    end
    check("ready_low_while_busy", ready_hi, 0);
    check("no_early_frame_done", fd_cnt, 0);
    ntt_done = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (in_ready) ready_hi = 1;
    end
    ntt_done = 1'b0;
    fall_cyc = cyc;
    check("ready_low_during_done", ready_hi, 0);
    for (int w = 0; w < 10 && fd_cnt == 0; w++) begin @(posedge clk); #1; end
    check("frame_done_latency", fd_cyc - fall_cyc, 1);
    check("ready_at_frame_done", fd_ready, 1);
    repeat (3) begin @(posedge clk); #1; end
    check("frame_done_count", fd_cnt, 1);
    check("start_count", start_cnt, 1);
    check("start_len", start_run, 2);
    check("start_latency", start_rise_cyc - last_we_cyc, 1);
    check("ntt_mode", mode_at_start, m);
    check("idle_after_frame", busy, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_bram_we"}, bram_we, 0);
    check({tag, "_bram_addr"}, bram_addr, 0);
    check({tag, "_bram_din"}, bram_din, 0);
    check({tag, "_start"}, ntt_start, 0);
    check({tag, "_mode"}, ntt_mode, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_err_len"}, err_len, 0);
  endtask

  initial begin
    repeat (3) begin @(posedge clk); #1; end
    check_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", in_ready, 1);

    // Ramp frame, held valid, NTT mode.
    send_frame(256, 1, 1'b0, 0, 0);
    run_transform(1'b0, 20, 0);
    compare_writes("ramp");

    // Random frame with reduction corners, gaps, INTT mode, long transform.
    send_frame(256, 1, 1'b1, 1, 1);
    run_transform(1'b1, 500, 1);
    compare_writes("rand");

    // Short frame: last on beat 99.
    send_frame(100, 1, 1'b0, 1, 0);
    check("short_err_len", err_len, 1);
    check("short_busy", busy, 0);
    repeat (10) begin @(posedge clk); #1; end
    check("short_no_start", start_cnt, 0);
    compare_writes("short");

    // Recovery frame clears the error and completes.
    send_frame(256, 1, 1'b1, 1, 1);
    run_transform(1'b1, 30, 0);
    check("recover_err_len", err_len, 0);
    compare_writes("recover");

    // Over-long frame: index 255 accepted without last.
    send_frame(256, 0, 1'b0, 1, 0);
    check("long_err_len", err_len, 1);
    check("long_busy", busy, 0);
    check("long_ready", in_ready, 1);
    repeat (10) begin @(posedge clk); #1; end
    check("long_no_start", start_cnt, 0);
    compare_writes("long");

    // Reset in the middle of a frame.
    send_frame(51, 0, 1'b1, 1, 0);
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    repeat (3) begin @(posedge clk); #1; end
    check("no_wr_after_rst", got_q.size(), 0);
    check("no_start_after_rst", start_cnt, 0);
    send_frame(256, 1, 1'b0, 0, 0);
    run_transform(1'b0, 10, 0);
    compare_writes("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
